// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Hazard FSM state encodings
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LU_STALL = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;
    localparam logic [1:0] ST_HALT     = 2'b11;

    // Stage-register control bundle
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_clr;
        logic idex_clr;
        logic exmem_clr;
    } stage_ctrl_t;

    // Canned control patterns: {enables[4:0], clears[2:0]}
    localparam stage_ctrl_t CTRL_FLOW   = 8'b11111_000; // normal advance
    localparam stage_ctrl_t CTRL_FREEZE = 8'b00000_000; // hold everything
    localparam stage_ctrl_t CTRL_FLUSH  = 8'b11111_111; // taken branch, three bubbles
    localparam stage_ctrl_t CTRL_LU     = 8'b00111_010; // hold PC and IF/ID, bubble into EX
    localparam stage_ctrl_t CTRL_RESET  = 8'b00000_111; // held while reset is asserted

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// rtl/pipeline_hazard_ctrl_fwd_sel.sv - forwarding select for one EX source operand
module fwd_sel #(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            mem_regwr,
    input  logic [RA_W-1:0] wb_dst,
    input  logic            wb_regwr,
    output logic [1:0]      sel
);
    import pipe_ctrl_pkg::*;

    // Youngest producer (EX/MEM) wins over MEM/WB; $0 is hardwired zero so never forwarded
    always_comb begin
        sel = FWD_REG;
        if (mem_regwr && (mem_dst != '0) && (mem_dst == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_regwr && (wb_dst != '0) && (wb_dst == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze and forwarding control for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int RA_W        = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic [RA_W-1:0]  ex_dst,
    input  logic             ex_regwr,
    input  logic             ex_memrd,
    input  logic [RA_W-1:0]  mem_dst,
    input  logic             mem_regwr,
    input  logic [RA_W-1:0]  wb_dst,
    input  logic             wb_regwr,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);
    import pipe_ctrl_pkg::*;

    localparam logic [8:0] TIMEOUT_V = 9'(MEM_TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [7:0]  wait_cnt;
    logic [8:0]  wait_cnt_inc;
    logic        mem_wait;
    logic        lu_hazard;
    logic        wait_inc;
    logic        wait_clr;
    logic        timeout;
    logic        flush_evt;
    logic        stall_evt;
    stage_ctrl_t ctrl;
    stage_ctrl_t ctrl_out;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;

    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .src       (ex_rs),
        .mem_dst   (mem_dst),
        .mem_regwr (mem_regwr),
        .wb_dst    (wb_dst),
        .wb_regwr  (wb_regwr),
        .sel       (sel_a)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .src       (ex_rt),
        .mem_dst   (mem_dst),
        .mem_regwr (mem_regwr),
        .wb_dst    (wb_dst),
        .wb_regwr  (wb_regwr),
        .sel       (sel_b)
    );

    assign mem_wait     = dmem_req && !dmem_ready;
    assign wait_cnt_inc = {1'b0, wait_cnt} + 9'd1;
    assign lu_hazard    = ex_memrd && ex_regwr && (ex_dst != '0) &&
                          ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    // Next-state and control decode: HALT > memory wait > branch flush > load-use
    always_comb begin
        ctrl      = CTRL_FLOW;
        state_nxt = state;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        timeout   = 1'b0;
        flush_evt = 1'b0;
        stall_evt = 1'b0;
        if (state == ST_HALT) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = ST_HALT;
        end else if (mem_wait) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = ST_MEM_WAIT;
            wait_inc  = 1'b1;
            if (wait_cnt_inc >= TIMEOUT_V) begin
                timeout   = 1'b1;
                state_nxt = ST_HALT;
            end
        end else begin
            // Leaving MEM_WAIT (or never in it): pipeline flows, a branch here is still honoured
            wait_clr  = 1'b1;
            state_nxt = ST_RUN;
            if (branch_taken) begin
                ctrl      = CTRL_FLUSH;
                flush_evt = 1'b1;
            end else if ((state == ST_RUN) && lu_hazard) begin
                ctrl      = CTRL_LU;
                stall_evt = 1'b1;
                state_nxt = ST_LU_STALL;
            end
        end
    end

    // Reset overrides all stage controls and parks forwarding on the register path
    always_comb begin
        ctrl_out = ctrl;
        fwd_a    = sel_a;
        fwd_b    = sel_b;
        if (!reset) begin
            ctrl_out = CTRL_RESET;
            fwd_a    = FWD_REG;
            fwd_b    = FWD_REG;
        end
    end

    assign pc_en     = ctrl_out.pc_en;
    assign ifid_en   = ctrl_out.ifid_en;
    assign idex_en   = ctrl_out.idex_en;
    assign exmem_en  = ctrl_out.exmem_en;
    assign memwb_en  = ctrl_out.memwb_en;
    assign ifid_clr  = ctrl_out.ifid_clr;
    assign idex_clr  = ctrl_out.idex_clr;
    assign exmem_clr = ctrl_out.exmem_clr;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Consecutive dmem wait cycles; frozen once halted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt_inc[7:0];
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err <= 1'b0;
        end else if (timeout) begin
            mem_err <= 1'b1;
        end
    end

    // Load-use stall counter, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Taken-branch flush counter, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (flush_evt && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
